uart_baud_cfg_ctrl: RTL and testbench

Configuration controller for the UART baud-tick generator. Owns the 2-bit baud-select bus feeding the tick generator (00=9600, 01=19200, 10=38400, 11=115200; tick rate 4x baud). Accepts software rate writes, and runs an auto-baud sequence that measures the start bit of a received 0x55 and picks the nearest rate. Any select change is applied only while the UART reports not busy.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_baud_cfg_ctrl_if.sv | 21 ++
 rtl/uart_rx_sync.sv | 20 ++
 rtl/uart_baud_cfg_ctrl.sv | 131 +++++++++++++
 tb/tb_uart_baud_cfg_ctrl.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: baud-select encodings, bit-period helper and auto-baud FSM states
package uart_pkg;
    localparam logic [1:0] SEL_9600   = 2'b00;
    localparam logic [1:0] SEL_19200  = 2'b01;
    localparam logic [1:0] SEL_38400  = 2'b10;
    localparam logic [1:0] SEL_115200 = 2'b11;
    localparam int CNT_W = 26;

    typedef enum logic [2:0] {IDLE, WAIT_EDGE, MEASURE, WAIT_QUIET, APPLY} ab_state_t;

    function automatic int bit_period(input int clk_freq, input logic [1:0] sel);
        return sel == SEL_9600  ? clk_freq / 9600 :
               sel == SEL_19200 ? clk_freq / 19200 :
               sel == SEL_38400 ? clk_freq / 38400 : clk_freq / 115200;
    endfunction
endpackage

// File: rtl/uart_baud_cfg_ctrl_if.sv
// uart_baud_cfg_ctrl_if: software/UART-side control and status of the baud config controller
interface uart_baud_cfg_ctrl_if;
    logic [1:0] sw_sel;
    logic       sw_wr;
    logic       ab_start;
    logic       uart_busy;
    logic [1:0] baud_sel;
    logic       sel_upd;
    logic       ab_busy;
    logic       ab_done;
    logic       ab_err;

    modport master (
        output sw_sel, sw_wr, ab_start, uart_busy,
        input  baud_sel, sel_upd, ab_busy, ab_done, ab_err
    );
    modport slave (
        input  sw_sel, sw_wr, ab_start, uart_busy,
        output baud_sel, sel_upd, ab_busy, ab_done, ab_err
    );
endinterface

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: 2-flop synchronizer for the raw rx line with rise/fall strobes
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic rxd,
    output logic rxs,
    output logic rise,
    output logic fall
);
    logic [2:0] sh;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sh <= '1;
        else sh <= {sh[1:0], rxd};
    end

    assign rxs  = sh[1];
    assign rise = sh[1] & ~sh[2];
    assign fall = ~sh[1] & sh[2];
endmodule

// File: rtl/uart_baud_cfg_ctrl.sv
// uart_baud_cfg_ctrl: owns the baud select; applies software writes and auto-baud results when the UART is idle
module uart_baud_cfg_ctrl
    import uart_pkg::*;
#(
    parameter int         CLK_FREQ       = 50_000_000,
    parameter int         TIMEOUT_CYCLES = 50_000_000,
    parameter logic [1:0] RESET_SEL      = 2'b00
) (
    input logic clk,
    input logic rst,
    input logic rxd,
    uart_baud_cfg_ctrl_if.slave cfg
);
    localparam int P0 = bit_period(CLK_FREQ, SEL_9600);
    localparam int P1 = bit_period(CLK_FREQ, SEL_19200);
    localparam int P2 = bit_period(CLK_FREQ, SEL_38400);
    localparam int P3 = bit_period(CLK_FREQ, SEL_115200);
    localparam logic [CNT_W-1:0] T01     = CNT_W'((P0 + P1) / 2);
    localparam logic [CNT_W-1:0] T12     = CNT_W'((P1 + P2) / 2);
    localparam logic [CNT_W-1:0] T23     = CNT_W'((P2 + P3) / 2);
    localparam logic [CNT_W-1:0] TMIN    = CNT_W'(P3 / 2);
    localparam logic [CNT_W-1:0] TMAX    = CNT_W'(P0 + P0 / 2);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    // quiet window is 11 bit times of the detected rate; compare against the last count before it
    localparam logic [CNT_W-1:0] Q0 = CNT_W'(11 * P0 - 1);
    localparam logic [CNT_W-1:0] Q1 = CNT_W'(11 * P1 - 1);
    localparam logic [CNT_W-1:0] Q2 = CNT_W'(11 * P2 - 1);
    localparam logic [CNT_W-1:0] Q3 = CNT_W'(11 * P3 - 1);

    ab_state_t        state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d, cnt_inc, quiet_last;
    logic [1:0]       sel_det, det_d, pending, pend_d, sel_d;
    logic             pend_valid, pv_d, upd_d, done_d, err_d;
    logic             rxs, rx_rise, rx_fall;

    uart_rx_sync u_sync (.clk(clk), .rst(rst), .rxd(rxd), .rxs(rxs), .rise(rx_rise), .fall(rx_fall));

    assign cnt_inc     = &cnt ? cnt : cnt + 1'b1;
    assign quiet_last  = sel_det == SEL_9600 ? Q0 : sel_det == SEL_19200 ? Q1 : sel_det == SEL_38400 ? Q2 : Q3;
    assign cfg.ab_busy = state != IDLE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            sel_det      <= RESET_SEL;
            pending      <= RESET_SEL;
            pend_valid   <= 1'b0;
            cfg.baud_sel <= RESET_SEL;
            cfg.sel_upd  <= 1'b0;
            cfg.ab_done  <= 1'b0;
            cfg.ab_err   <= 1'b0;
        end else begin
            state        <= state_d;
            cnt          <= cnt_d;
            sel_det      <= det_d;
            pending      <= pend_d;
            pend_valid   <= pv_d;
            cfg.baud_sel <= sel_d;
            cfg.sel_upd  <= upd_d;
            cfg.ab_done  <= done_d;
            cfg.ab_err   <= err_d;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        det_d   = sel_det;
        pend_d  = pending;
        pv_d    = pend_valid;
        sel_d   = cfg.baud_sel;
        upd_d   = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state)
            IDLE: begin
                if (cfg.ab_start) begin
                    state_d = WAIT_EDGE;
                    cnt_d   = '0;
                end else if (cfg.sw_wr) begin
                    pend_d = cfg.sw_sel;
                    pv_d   = 1'b1;
                end
                if (pend_valid && !cfg.uart_busy) begin
                    sel_d = pending;
                    upd_d = 1'b1;
                    pv_d  = cfg.sw_wr && !cfg.ab_start;
                end
            end
            WAIT_EDGE: begin
                if (!rxs) begin
                    state_d = MEASURE;
                    cnt_d   = CNT_W'(1);
                end else if (cnt == TO_LAST) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else cnt_d = cnt_inc;
            end
            MEASURE: begin
                if (!rx_rise) cnt_d = cnt_inc;
                else if (cnt < TMIN || cnt > TMAX) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else begin
                    det_d   = cnt >= T01 ? SEL_9600 : cnt >= T12 ? SEL_19200 : cnt >= T23 ? SEL_38400 : SEL_115200;
                    state_d = WAIT_QUIET;
                    cnt_d   = '0;
                end
            end
            WAIT_QUIET: begin
                // a falling edge restarts the window; the count then holds at zero while the line is low
                if (rx_fall) cnt_d = '0;
                else if (rxs) begin
                    if (cnt == quiet_last) state_d = APPLY;
                    else cnt_d = cnt_inc;
                end
            end
            APPLY: begin
                if (!cfg.uart_busy) begin
                    sel_d   = sel_det;
                    upd_d   = 1'b1;
                    done_d  = 1'b1;
                    pv_d    = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_uart_baud_cfg_ctrl.sv
// tb_uart_baud_cfg_ctrl: randomized auto-baud/software-write stimulus with a queued scoreboard of expected select events
module tb_uart_baud_cfg_ctrl;
    localparam int CF = 2_000_000;
    localparam int TO = 1000;

    typedef struct {
        logic [2:0] code;
        int         sel;
        int         lo;
        int         hi;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rxd = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   cur_sel = 0;
    int   prev_sel = 0;
    int   per[4];
    exp_t q[$];
    exp_t me;
    logic [2:0] mcode;
    logic [9:0] fr = {1'b1, 8'h55, 1'b0};

    uart_baud_cfg_ctrl_if bus ();

    uart_baud_cfg_ctrl #(.CLK_FREQ(CF), .TIMEOUT_CYCLES(TO), .RESET_SEL(2'b00)) dut (
        .clk(clk), .rst(rst), .rxd(rxd), .cfg(bus)
    );

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d cycle=%0d", nm, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // nearest nominal rate by midpoint between neighbouring bit periods; -1 when out of range
    function automatic int classify(input int c);
        if (c < per[3] / 2 || c > per[0] + per[0] / 2) return -1;
        for (int k = 0; k < 3; k++) if (c >= (per[k] + per[k + 1]) / 2) return k;
        return 3;
    endfunction

    task automatic wait_drain(input int lim);
        int n = 0;
        while (q.size() != 0 && n < lim) begin
            tick(1);
            n++;
        end
        check("queue_drained", q.size(), 0);
        q.delete();
        tick(5);
    endtask

    task automatic run_ab(input int p, input bit hold, input bit with_sw);
        int k, f, r, b, qt;
        k = classify(p);
        bus.ab_start = 1'b1;
        if (with_sw) begin
            bus.sw_wr  = 1'b1;
            bus.sw_sel = 2'(k < 0 ? cur_sel + 1 : 3 - k);
        end
        tick(1);
        bus.ab_start = 1'b0;
        bus.sw_wr    = 1'b0;
        check("ab_busy_set", bus.ab_busy, 1);
        tick($urandom_range(2, 6));
        f = cyc;
        if (k < 0) begin
            q.push_back('{3'b100, cur_sel, f + p + 1, f + p + 4});
            rxd = 1'b0;
            tick(p);
            rxd = 1'b1;
        end else begin
            qt = 11 * per[k];
            r  = f + 9 * p;
            b  = r + qt + (hold ? int'($urandom_range(5, 40)) : 0);
            q.push_back('{3'b011, k, hold ? b + 1 : r + qt + 1, hold ? b + 1 : r + qt + 5});
            cur_sel = k;
            bus.uart_busy = hold;
            for (int i = 0; i < 10; i++) begin
                rxd = fr[i];
                tick(p);
            end
            while (cyc < b) tick(1);
            bus.uart_busy = 1'b0;
        end
        wait_drain(3000);
    endtask

    always @(negedge clk) begin
        mcode = {bus.ab_err, bus.ab_done, bus.sel_upd};
        if (!rst) begin
            if (int'(bus.baud_sel) != prev_sel && !bus.sel_upd) begin
                checks++;
                errors++;
                $display("FAIL silent_sel_change actual=%0d required=%0d cycle=%0d", bus.baud_sel, prev_sel, cyc);
            end
            if (mcode != 3'b000) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_event actual=%b required=none cycle=%0d", mcode, cyc);
                end else begin
                    me = q.pop_front();
                    check("event_code", int'(mcode), int'(me.code));
                    check("event_sel", int'(bus.baud_sel), me.sel);
                    if (cyc < me.lo || cyc > me.hi)
                        $display("FAIL event_time actual=%0d required=%0d..%0d", cyc, me.lo, me.hi);
                    check("event_in_window", int'(cyc >= me.lo && cyc <= me.hi), 1);
                    if (mcode[2:1] != 2'b00) check("busy_cleared", bus.ab_busy, 0);
                end
            end
        end
        prev_sel = bus.baud_sel;
    end

    initial begin
        int p, r, v;
        per = '{CF / 9600, CF / 19200, CF / 38400, CF / 115200};
        bus.sw_sel = 2'b00;
        bus.sw_wr = 1'b0;
        bus.ab_start = 1'b0;
        bus.uart_busy = 1'b0;
        tick(3);
        check("rst_baud_sel", bus.baud_sel, 0);
        check("rst_flags", {bus.sel_upd, bus.ab_busy, bus.ab_done, bus.ab_err}, 0);
        rst = 1'b0;
        tick(3);

        run_ab(per[3], 1'b0, 1'b0);
        run_ab(per[0], 1'b0, 1'b0);
        run_ab(per[2], 1'b1, 1'b0);
        run_ab(4, 1'b0, 1'b0);

        // timeout: line stays high after start
        q.push_back('{3'b100, cur_sel, cyc + TO + 1, cyc + TO + 1});
        bus.ab_start = 1'b1;
        tick(1);
        bus.ab_start = 1'b0;
        wait_drain(TO + 50);

        // software write held off by uart_busy, overwritten once before apply
        bus.uart_busy = 1'b1;
        bus.sw_sel = 2'b11;
        bus.sw_wr = 1'b1;
        tick(1);
        bus.sw_sel = 2'b10;
        tick(1);
        bus.sw_wr = 1'b0;
        tick($urandom_range(3, 20));
        check("sw_held_while_busy", bus.baud_sel, cur_sel);
        q.push_back('{3'b001, 2, cyc + 1, cyc + 1});
        cur_sel = 2;
        bus.uart_busy = 1'b0;
        wait_drain(20);

        run_ab(per[3], 1'b0, 1'b1);
        tick(30);

        // reset in the middle of a measurement
        bus.ab_start = 1'b1;
        tick(1);
        bus.ab_start = 1'b0;
        tick(3);
        rxd = 1'b0;
        tick(20);
        rst = 1'b1;
        tick(2);
        check("midrst_baud_sel", bus.baud_sel, 0);
        check("midrst_ab_busy", bus.ab_busy, 0);
        cur_sel = 0;
        rxd = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(3);
        run_ab(per[1], 1'b0, 1'b0);

        for (int i = 0; i < 8; i++) begin
            r = $urandom_range(0, 5);
            if (r < 4) begin
                v = per[r] / 10;
                p = per[r] + int'($urandom_range(0, 2 * v)) - v;
            end else if (r == 4) p = $urandom_range(2, 7);
            else p = $urandom_range(320, 400);
            run_ab(p, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
